// File: rtl/sd_spi_pkg.sv
// Shared constants and state types for the SPI-mode SD card responder.
package sd_spi_pkg;
    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD24 = 6'd24;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam logic [7:0] R1_READY   = 8'h00;
    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;

    localparam logic [7:0] TOK_START    = 8'hFE;
    localparam logic [7:0] TOK_DATA_ACC = 8'h05;
    localparam logic [7:0] FILL_BYTE    = 8'hFF;
    localparam logic [31:0] OCR_VALUE   = 32'hC0FF_8000;

    typedef enum logic [3:0] {
        CMD_WAIT, CMD_RX, NCR, R1, R_EXTRA, NAC, RD_TOKEN, RD_DATA, RD_CRC,
        WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, BUSY
    } state_e;

    // What follows R1 once it has been sent.
    typedef enum logic [1:0] {RSP_R1, RSP_EXTRA, RSP_READ, RSP_WRITE} rsp_e;
endpackage

// File: rtl/spi_slave_byte.sv
// Mode-0 SPI slave byte engine: synchronizes the pins onto the system clock,
// shifts MOSI in on SCLK rises and MISO out on falls, one byte at a time.
module spi_slave_byte (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       cs_i,
    input  logic       tx_load_i,
    input  logic [7:0] tx_byte_i,
    output logic       miso_o,
    output logic       rx_stb_o,
    output logic [7:0] rx_byte_o,
    output logic       cs_hi_o
);
    logic [1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic       sclk_prev_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_q, tx_q;
    logic       rise, fall;

    assign rise      = sclk_sync_q[1] & ~sclk_prev_q;
    assign fall      = ~sclk_sync_q[1] & sclk_prev_q;
    assign cs_hi_o   = cs_sync_q[1];
    assign rx_byte_o = {rx_q[6:0], mosi_sync_q[1]};
    assign rx_stb_o  = rise & ~cs_sync_q[1] & (bit_cnt_q == 3'd7);
    assign miso_o    = tx_q[7];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b11;
            cs_sync_q   <= 2'b11;
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'hFF;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            cs_sync_q   <= {cs_sync_q[0], cs_i};
            sclk_prev_q <= sclk_sync_q[1];
            if (cs_sync_q[1]) begin
                bit_cnt_q <= 3'd0;
                rx_q      <= 8'h00;
                tx_q      <= 8'hFF;
            end else begin
                if (rise) begin
                    rx_q      <= rx_byte_o;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
                // The fall right after a byte boundary must keep the freshly loaded MSB.
                if (tx_load_i)
                    tx_q <= tx_byte_i;
                else if (fall && bit_cnt_q != 3'd0)
                    tx_q <= {tx_q[6:0], 1'b1};
            end
        end
    end
endmodule

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card model: command decode, R1/R3/R7 responses and single-block
// read/write against one internal block buffer.
module sd_spi_card_responder
    import sd_spi_pkg::*;
#(
    parameter int BLOCK_BYTES = 512,
    parameter int NCR_BYTES   = 1,
    parameter int NAC_BYTES   = 2,
    parameter int BUSY_BYTES  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        CS,
    output logic        MISO,
    output logic        CMD_STB,
    output logic [5:0]  CMD_IDX,
    output logic [31:0] CMD_ARG,
    output logic        WR_DONE,
    output logic        IDLE
);
    localparam int AW = $clog2(BLOCK_BYTES);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ARG_LAST   = CW'(4);
    localparam logic [CW-1:0] EXTRA_LAST = CW'(3);
    localparam logic [CW-1:0] CRC_LAST   = CW'(1);
    localparam logic [CW-1:0] NCR_LAST   = CW'(NCR_BYTES - 1);
    localparam logic [CW-1:0] NAC_LAST   = CW'(NAC_BYTES - 1);
    localparam logic [CW-1:0] BUSY_LAST  = CW'(BUSY_BYTES - 1);
    localparam logic [CW-1:0] DATA_LAST  = CW'(BLOCK_BYTES - 1);

    state_e        state_q, state_d;
    rsp_e          rsp_q, rsp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [5:0]    cmd_q, cmd_d, cmd_idx_q, cmd_idx_d;
    logic [31:0]   arg_q, arg_d, ext_q, ext_d, cmd_arg_q, cmd_arg_d;
    logic [7:0]    r1_q, r1_d, idle_r1;
    logic          idle_q, idle_d, app_q, app_d, stb_q, stb_d, wr_done_q, wr_done_d;
    logic [7:0]    buf_mem [BLOCK_BYTES];
    logic [7:0]    rdata_q, rx_byte, tx_byte;
    logic          rx_stb, cs_hi, wr_en;

    spi_slave_byte u_spi (
        .clk_i(CLK), .rst_i(RST), .sclk_i(SCLK), .mosi_i(MOSI), .cs_i(CS),
        .tx_load_i(rx_stb), .tx_byte_i(tx_byte), .miso_o(MISO),
        .rx_stb_o(rx_stb), .rx_byte_o(rx_byte), .cs_hi_o(cs_hi)
    );

    assign idle_r1 = {7'b0, idle_q};
    assign CMD_STB = stb_q;
    assign CMD_IDX = cmd_idx_q;
    assign CMD_ARG = cmd_arg_q;
    assign WR_DONE = wr_done_q;
    assign IDLE    = idle_q;

    always_comb begin
        state_d = state_q;  rsp_d = rsp_q;  cnt_d = cnt_q;  idx_d = idx_q;
        cmd_d = cmd_q;  arg_d = arg_q;  ext_d = ext_q;  r1_d = r1_q;
        idle_d = idle_q;  app_d = app_q;  stb_d = 1'b0;  wr_done_d = 1'b0;
        cmd_idx_d = cmd_idx_q;  cmd_arg_d = cmd_arg_q;
        tx_byte = FILL_BYTE;  wr_en = 1'b0;
        if (cs_hi) begin
            state_d = CMD_WAIT;
        end else if (rx_stb) begin
            // Every byte boundary: advance and choose the byte to shift out next.
            case (state_q)
                CMD_WAIT: if (rx_byte[7:6] == 2'b01) begin
                    state_d = CMD_RX;  cmd_d = rx_byte[5:0];  cnt_d = '0;
                end
                CMD_RX: if (cnt_q == ARG_LAST) begin
                    stb_d = 1'b1;  cmd_idx_d = cmd_q;  cmd_arg_d = arg_q;
                    app_d = (cmd_q == CMD55);  rsp_d = RSP_R1;  ext_d = '0;
                    state_d = NCR;  cnt_d = '0;
                    case (cmd_q)
                        CMD0:  begin r1_d = R1_IDLE;  idle_d = 1'b1; end
                        CMD8:  begin r1_d = idle_r1;  ext_d = {24'h000001, arg_q[7:0]};  rsp_d = RSP_EXTRA; end
                        CMD55: r1_d = idle_r1;
                        CMD41: if (app_q) begin r1_d = R1_READY;  idle_d = 1'b0; end
                               else r1_d = idle_r1 | R1_ILLEGAL;
                        CMD58: begin r1_d = idle_r1;  ext_d = OCR_VALUE;  rsp_d = RSP_EXTRA; end
                        CMD17, CMD24:
                            if (idle_q) r1_d = R1_IDLE | R1_ILLEGAL;
                            else begin
                                r1_d  = R1_READY;
                                rsp_d = (cmd_q == CMD17) ? RSP_READ : RSP_WRITE;
                            end
                        default: r1_d = idle_r1 | R1_ILLEGAL;
                    endcase
                end else begin
                    arg_d = {arg_q[23:0], rx_byte};  cnt_d = cnt_q + 1'b1;
                end
                NCR: if (cnt_q == NCR_LAST) begin state_d = R1;  tx_byte = r1_q; end
                     else cnt_d = cnt_q + 1'b1;
                R1: begin
                    cnt_d = '0;  idx_d = '0;
                    case (rsp_q)
                        RSP_EXTRA: begin
                            state_d = R_EXTRA;  tx_byte = ext_q[31:24];  ext_d = {ext_q[23:0], 8'h00};
                        end
                        RSP_READ:  state_d = NAC;
                        RSP_WRITE: state_d = WR_TOKEN;
                        default:   state_d = CMD_WAIT;
                    endcase
                end
                R_EXTRA: if (cnt_q == EXTRA_LAST) state_d = CMD_WAIT;
                    else begin
                        cnt_d = cnt_q + 1'b1;  tx_byte = ext_q[31:24];  ext_d = {ext_q[23:0], 8'h00};
                    end
                NAC: if (cnt_q == NAC_LAST) begin state_d = RD_TOKEN;  tx_byte = TOK_START; end
                     else cnt_d = cnt_q + 1'b1;
                RD_TOKEN: begin
                    state_d = RD_DATA;  cnt_d = '0;  tx_byte = rdata_q;  idx_d = idx_q + 1'b1;
                end
                RD_DATA: if (cnt_q == DATA_LAST) begin state_d = RD_CRC;  cnt_d = '0; end
                    else begin tx_byte = rdata_q;  idx_d = idx_q + 1'b1;  cnt_d = cnt_q + 1'b1; end
                RD_CRC: if (cnt_q == CRC_LAST) state_d = CMD_WAIT;
                        else cnt_d = cnt_q + 1'b1;
                WR_TOKEN: if (rx_byte == TOK_START) begin state_d = WR_DATA;  cnt_d = '0; end
                WR_DATA: begin
                    wr_en = 1'b1;  idx_d = idx_q + 1'b1;
                    if (cnt_q == DATA_LAST) begin state_d = WR_CRC;  cnt_d = '0; end
                    else cnt_d = cnt_q + 1'b1;
                end
                WR_CRC: if (cnt_q == CRC_LAST) begin
                    state_d = WR_RESP;  tx_byte = TOK_DATA_ACC;  wr_done_d = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
                WR_RESP: begin state_d = BUSY;  cnt_d = '0;  tx_byte = 8'h00; end
                BUSY: if (cnt_q == BUSY_LAST) state_d = CMD_WAIT;
                      else begin cnt_d = cnt_q + 1'b1;  tx_byte = 8'h00; end
                default: state_d = CMD_WAIT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= CMD_WAIT;  rsp_q <= RSP_R1;  cnt_q <= '0;  idx_q <= '0;
            cmd_q <= '0;  arg_q <= '0;  ext_q <= '0;  r1_q <= '0;
            idle_q <= 1'b1;  app_q <= 1'b0;  stb_q <= 1'b0;  wr_done_q <= 1'b0;
            cmd_idx_q <= '0;  cmd_arg_q <= '0;
        end else begin
            state_q <= state_d;  rsp_q <= rsp_d;  cnt_q <= cnt_d;  idx_q <= idx_d;
            cmd_q <= cmd_d;  arg_q <= arg_d;  ext_q <= ext_d;  r1_q <= r1_d;
            idle_q <= idle_d;  app_q <= app_d;  stb_q <= stb_d;  wr_done_q <= wr_done_d;
            cmd_idx_q <= cmd_idx_d;  cmd_arg_q <= cmd_arg_d;
        end
    end

    // Read data trails the index by one clock, far ahead of the next byte load.
    always_ff @(posedge CLK) begin
        if (wr_en) buf_mem[idx_q] <= rx_byte;
        rdata_q <= buf_mem[idx_q];
    end
endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench: an SPI master walks the card through init, register reads,
// a block write/read-back and an aborted command.
module tb_sd_spi_card_responder;
    logic        CLK, RST, SCLK, MOSI, CS;
    logic        MISO, CMD_STB, WR_DONE, IDLE;
    logic [5:0]  CMD_IDX;
    logic [31:0] CMD_ARG;
    int n_vec = 0, n_bad = 0, stb_cnt = 0, done_cnt = 0, exp_stb = 0;

    sd_spi_card_responder dut (
        .CLK(CLK), .RST(RST), .SCLK(SCLK), .MOSI(MOSI), .CS(CS), .MISO(MISO),
        .CMD_STB(CMD_STB), .CMD_IDX(CMD_IDX), .CMD_ARG(CMD_ARG),
        .WR_DONE(WR_DONE), .IDLE(IDLE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (CMD_STB) stb_cnt++;
        if (WR_DONE) done_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One byte, mode 0: MOSI set while SCLK low, MISO sampled just before the rise.
    task automatic xfer(input logic [7:0] mo, output logic [7:0] mi);
        for (int b = 7; b >= 0; b--) begin
            MOSI = mo[b];
            #40;
            mi[b] = MISO;
            SCLK = 1'b1;
            #40;
            SCLK = 1'b0;
        end
    endtask

    task automatic put(input logic [7:0] mo);
        logic [7:0] d;
        xfer(mo, d);
    endtask

    task automatic get(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        xfer(8'hFF, d);
        chk(tag, {24'h0, d}, {24'h0, exp});
    endtask

    // Selects the card, sends a frame and checks the single NCR filler byte.
    task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        CS = 1'b0;
        #100;
        put({2'b01, idx});
        put(arg[31:24]); put(arg[23:16]); put(arg[15:8]); put(arg[7:0]);
        put(crc);
        exp_stb++;
        get("ncr_fill", 8'hFF);
    endtask

    task automatic deselect();
        #100;
        CS = 1'b1;
        #200;
    endtask

    initial begin
        RST = 1'b1; SCLK = 1'b0; MOSI = 1'b1; CS = 1'b1;
        #53;
        RST = 1'b0;
        #50;
        chk("rst_miso",    {31'h0, MISO},    32'h1);
        chk("rst_cmd_stb", {31'h0, CMD_STB}, 32'h0);
        chk("rst_cmd_idx", {26'h0, CMD_IDX}, 32'h0);
        chk("rst_cmd_arg", CMD_ARG,          32'h0);
        chk("rst_wr_done", {31'h0, WR_DONE}, 32'h0);
        chk("rst_idle",    {31'h0, IDLE},    32'h1);

        cmd(6'd0, 32'h0, 8'h95);
        get("cmd0_r1", 8'h01);
        deselect();
        chk("cmd0_stb", stb_cnt, exp_stb);
        chk("cmd0_idx", {26'h0, CMD_IDX}, 32'd0);

        cmd(6'd8, 32'h0000_01AA, 8'h87);
        get("cmd8_r1", 8'h01);
        get("r7_b0", 8'h00); get("r7_b1", 8'h00); get("r7_b2", 8'h01); get("r7_b3", 8'hAA);
        deselect();
        chk("cmd8_idx", {26'h0, CMD_IDX}, 32'd8);
        chk("cmd8_arg", CMD_ARG, 32'h0000_01AA);

        cmd(6'd41, 32'h4000_0000, 8'h77);
        get("cmd41_noapp_r1", 8'h05);
        deselect();
        chk("cmd41_noapp_idle", {31'h0, IDLE}, 32'h1);

        cmd(6'd17, 32'h0, 8'hFF);
        get("cmd17_idle_r1", 8'h05);
        get("cmd17_idle_notok0", 8'hFF);
        get("cmd17_idle_notok1", 8'hFF);
        deselect();

        cmd(6'd55, 32'h0, 8'h65);
        get("cmd55_r1", 8'h01);
        deselect();
        cmd(6'd41, 32'h4000_0000, 8'h77);
        get("acmd41_r1", 8'h00);
        deselect();
        chk("acmd41_idle", {31'h0, IDLE}, 32'h0);

        cmd(6'd58, 32'h0, 8'hFD);
        get("cmd58_r1", 8'h00);
        get("ocr_b0", 8'hC0); get("ocr_b1", 8'hFF); get("ocr_b2", 8'h80); get("ocr_b3", 8'h00);
        deselect();

        cmd(6'd24, 32'd7, 8'hFF);
        get("cmd24_r1", 8'h00);
        put(8'hFF);
        put(8'hFE);
        for (int i = 0; i < 512; i++) put(i[7:0]);
        put(8'hFF); put(8'hFF);
        get("wr_resp", 8'h05);
        chk("wr_done_cnt", done_cnt, 1);
        for (int i = 0; i < 4; i++) get("wr_busy", 8'h00);
        get("wr_after_busy", 8'hFF);
        deselect();
        chk("cmd24_idx", {26'h0, CMD_IDX}, 32'd24);
        chk("cmd24_arg", CMD_ARG, 32'd7);

        cmd(6'd17, 32'd7, 8'hFF);
        get("cmd17_r1", 8'h00);
        get("nac0", 8'hFF); get("nac1", 8'hFF);
        get("rd_token", 8'hFE);
        for (int i = 0; i < 512; i++) get("rd_data", i[7:0]);
        get("rd_crc0", 8'hFF); get("rd_crc1", 8'hFF);
        deselect();
        chk("rd_no_wr_done", done_cnt, 1);

        // Abort a command frame partway through its third argument byte.
        CS = 1'b0;
        #100;
        put(8'h51); put(8'h00); put(8'h00);
        for (int b = 0; b < 4; b++) begin
            MOSI = 1'b0; #40; SCLK = 1'b1; #40; SCLK = 1'b0;
        end
        deselect();
        chk("abort_miso_hi", {31'h0, MISO}, 32'h1);
        chk("abort_no_stb", stb_cnt, exp_stb);
        cmd(6'd0, 32'h0, 8'h95);
        get("post_abort_r1", 8'h01);
        deselect();
        chk("post_abort_idle", {31'h0, IDLE}, 32'h1);
        chk("post_abort_stb", stb_cnt, exp_stb);
        chk("post_abort_idx", {26'h0, CMD_IDX}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sd_spi_card_responder.md
# sd_spi_card_responder

SPI-mode SD card model: the card-side responder to the `card_driver` SPI master. It samples SCLK/MOSI/CS on the system clock, decodes 6-byte SD commands, and answers with R1/R3/R7 responses. It serves single-block reads and writes from one internal 512-byte buffer. It is used in simulation benches and FPGA loopback builds in place of a physical card.

## Interface
Parameters:
- `BLOCK_BYTES`, 512, data block length; also the buffer depth.
- `NCR_BYTES`, 1, 0xFF filler bytes between the command CRC byte and R1 (1..8).
- `NAC_BYTES`, 2, 0xFF filler bytes between the CMD17 R1 and the 0xFE start token.
- `BUSY_BYTES`, 4, 0x00 busy bytes after the CMD24 data response.

Ports:
- `CLK` in 1: system clock; must be ≥8× the SCLK frequency.
- `RST` in 1: asynchronous, active-high reset.
- `SCLK` in 1: SPI clock from the master (mode 0), asynchronous to `CLK`.
- `MOSI` in 1: serial data from the master, MSB first.
- `CS` in 1: chip select, active low.
- `MISO` out 1: serial data to the master. Reset value 1.
- `CMD_STB` out 1: one-`CLK` pulse per decoded command frame. Reset value 0.
- `CMD_IDX` out 6: index of the last command. Reset value 0.
- `CMD_ARG` out 32: argument of the last command. Reset value 0.
- `WR_DONE` out 1: one-`CLK` pulse when a block write is stored. Reset value 0.
- `IDLE` out 1: card idle-state flag. Reset value 1.

## Operation
- Inputs pass through a 2-flop synchronizer, followed by SCLK edge detection.
- `bit_cnt` (3 bits) counts rising edges. MOSI is shifted in on each rising edge. On the 8th edge a byte completes, `bit_cnt` wraps to 0, and the next TX byte is loaded.
- `MISO` = `tx[7]`. Falling edges shift `tx` left, except when `bit_cnt==0`.
- CS high: `MISO`=1, `tx`=0xFF, `bit_cnt`=0, FSM returns to `CMD_WAIT`. The `IDLE` flag and the buffer are kept.
- FSM states: `CMD_WAIT`, `CMD_RX`, `NCR`, `R1`, `R_EXTRA`, `NAC`, `RD_TOKEN`, `RD_DATA`, `RD_CRC`, `WR_TOKEN`, `WR_DATA`, `WR_CRC`, `WR_RESP`, `BUSY`.
- `CMD_WAIT`: a byte with bits[7:6]=01 starts a frame. Any other byte keeps the FSM in `CMD_WAIT` with TX 0xFF.
- `CMD_RX`: collects 5 more bytes (4 argument bytes, then CRC). The CRC is not checked. At the end, `CMD_STB` pulses and `CMD_IDX`/`CMD_ARG` update.
- `NCR`: sends `NCR_BYTES` × 0xFF, then `R1`.
- R1 is 0x01 when `IDLE`=1 and 0x00 otherwise, per command:
  - CMD0: R1 = 0x01. Sets `IDLE`.
  - CMD8: R1, then R7 = 0x00,0x00,0x01,`arg[7:0]`.
  - CMD55: R1. Sets `app_cmd`.
  - CMD41 with `app_cmd`: R1 = 0x00. Clears `IDLE`.
  - CMD58: R1, then OCR = 0xC0,0xFF,0x80,0x00.
  - CMD17 / CMD24: R1 = 0x00 when not idle. When idle, R1 = 0x05 and no data phase follows.
  - Any other command, or CMD41 without `app_cmd`: R1 = `IDLE`|0x04.
- `app_cmd` is cleared by every command other than CMD55.
- Read (CMD17): `NAC_BYTES` × 0xFF, token 0xFE, `BLOCK_BYTES` buffer bytes from index 0, then 2 CRC bytes 0xFF,0xFF, then `CMD_WAIT`.
- Write (CMD24):
  - `WR_TOKEN` ignores bytes until 0xFE arrives.
  - `WR_DATA` writes `BLOCK_BYTES` bytes to the buffer in index order.
  - `WR_CRC` discards 2 bytes.
  - `WR_RESP` sends 0x05 and pulses `WR_DONE`.
  - `BUSY` sends `BUSY_BYTES` × 0x00, then `CMD_WAIT`.
- The block address in `CMD_ARG` is reported only; every address maps to the one buffer.
- Byte counters are sized to `$clog2(BLOCK_BYTES)+1`. The buffer index wraps to 0 at each data phase start.

## Timing
- MISO MSB is valid ≤3 `CLK` after the 8th rising SCLK edge of the preceding byte, i.e. before the next falling edge.
- `CMD_STB` fires ≤4 `CLK` after the 48th rising SCLK edge.
- `WR_DONE` fires ≤4 `CLK` after the last CRC byte completes.
- Buffer reads are synchronous. The next read byte is fetched during the current byte, so it is ready at load time.
- SCLK edges while CS is high are ignored.
- If CS rises mid-byte, the partial byte is discarded.
- If CS rises mid-write, bytes already written stay in the buffer and `WR_DONE` is not pulsed.

## Structure
- Package `sd_spi_pkg`:
  - command indices (0, 8, 17, 24, 41, 55, 58)
  - R1 bit constants
  - tokens 0xFE and 0x05
  - OCR constant
  - FSM state enum
- Sub-module `spi_slave_byte`: synchronizer, edge detect, RX/TX shift registers, `bit_cnt`. It outputs `rx_stb`/`rx_byte` and accepts a `tx_byte` load.
- The top level holds the FSM, counters, flags, and a 512×8 inferred RAM.

## Test plan
- After reset, send CMD0 (40 00 00 00 00 95) → `NCR_BYTES` × 0xFF then R1 0x01; `CMD_STB` pulses with `CMD_IDX`=0.
- Send CMD8 with arg 0x000001AA → R1 0x01, then 00 00 01 AA.
- Send CMD55 then CMD41 → R1 0x01 then 0x00; `IDLE` falls.
- Send CMD41 without a preceding CMD55 → R1 0x05 (`IDLE`|illegal, since `IDLE`=1).
- With the card ready, CMD24 arg 7: 0xFE, bytes i=0..511 valued i[7:0], CRC FF FF → 0x05, 4 × 0x00; `WR_DONE` pulses. Then CMD17 → 0xFF ×2, 0xFE, bytes 00..FF twice, FF FF.
- Send CMD17 while idle → R1 0x05 and no token. CS high during the 3rd argument byte, then a fresh CMD0 → clean 0x01 response.
